multicycle_control_fsm: RTL and testbench

Sequencing control unit for the multi-cycle RV32I core. It steps each instruction through IF/ID/EX/MEM/WB and drives the program counter write enable, IR/register/memory strobes and datapath mux selects. It also inserts configurable memory wait states. It sits beside the PC register, IR, ALUOut/MDR registers and the shared instruction/data memory.

---
 rtl/multicycle_control_fsm_pkg.sv | 49 ++++
 rtl/multicycle_control_fsm_mem_wait_timer.sv | 27 ++
 rtl/multicycle_control_fsm.sv | 185 ++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared control definitions for the multi-cycle RV32I core: opcodes, state
// encodings and datapath mux/ALU select encodings used by control and datapath.
package multicycle_control_fsm_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_e;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

  localparam logic       SRC_A_PC  = 1'b0;
  localparam logic       SRC_A_RS1 = 1'b1;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_ALU    = 2'b10;

  localparam logic       PC_SRC_ALU    = 1'b0;
  localparam logic       PC_SRC_ALUOUT = 1'b1;

  function automatic logic known_opcode(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE,
      OP_BRANCH, OP_JAL, OP_JALR, OP_ECALL: known_opcode = 1'b1;
      default:                              known_opcode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// Memory wait-state counter shared by the IF and MEM phases; done flags the
// final cycle of an access.
module mem_wait_timer #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic done
);

  localparam int unsigned W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = clear ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done = (cnt_q == W'(MEM_WAIT));

endmodule

// File: rtl/multicycle_control_fsm.sv
// Sequencing control for the multi-cycle RV32I core: IF/ID/EX/MEM/WB with
// configurable memory wait states and a halt state entered on ecall.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       bcond,
  input  logic       is_halted,
  output logic       pc_write,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       pc_source,
  output logic       is_ecall,
  output logic [2:0] state
);

  state_e     state_q, state_d;
  logic       wait_done, timer_clear;
  logic       pc_write_c, ir_write_c, i_or_d_c, mem_read_c, mem_write_c;
  logic       reg_write_c, alu_src_a_c, pc_source_c, is_ecall_c;
  logic [1:0] wb_sel_c, alu_src_b_c, alu_op_c;

  mem_wait_timer #(
    .MEM_WAIT(MEM_WAIT)
  ) u_wait (
    .clk  (clk),
    .reset(reset),
    .clear(timer_clear),
    .done (wait_done)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IF;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    i_or_d_c    = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    wb_sel_c    = WB_ALUOUT;
    alu_src_a_c = SRC_A_PC;
    alu_src_b_c = SRC_B_RS2;
    alu_op_c    = ALU_OP_ADD;
    pc_source_c = PC_SRC_ALU;
    is_ecall_c  = 1'b0;

    case (state_q)
      ST_IF: begin
        mem_read_c = 1'b1;
        if (wait_done) begin
          ir_write_c = 1'b1;
          state_d    = ST_ID;
        end
      end
      ST_ID: begin
        alu_src_b_c = SRC_B_IMM;
        state_d     = known_opcode(opcode) ? ST_EX : ST_WB;
      end
      ST_EX: begin
        case (opcode)
          OP_R: begin
            alu_src_a_c = SRC_A_RS1;
            alu_op_c    = ALU_OP_FUNCT;
            state_d     = ST_WB;
          end
          OP_I: begin
            alu_src_a_c = SRC_A_RS1;
            alu_src_b_c = SRC_B_IMM;
            alu_op_c    = ALU_OP_FUNCT;
            state_d     = ST_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a_c = SRC_A_RS1;
            alu_src_b_c = SRC_B_IMM;
            state_d     = ST_MEM;
          end
          OP_BRANCH: begin
            // Taken branch redirects from ALUOut (target computed in ID); Mealy on bcond.
            alu_src_a_c = SRC_A_RS1;
            alu_op_c    = ALU_OP_BRANCH;
            if (bcond) begin
              pc_write_c  = 1'b1;
              pc_source_c = PC_SRC_ALUOUT;
              state_d     = ST_IF;
            end else begin
              state_d = ST_WB;
            end
          end
          OP_JAL: begin
            alu_src_b_c = SRC_B_FOUR;
            reg_write_c = 1'b1;
            wb_sel_c    = WB_ALU;
            pc_write_c  = 1'b1;
            pc_source_c = PC_SRC_ALUOUT;
            state_d     = ST_IF;
          end
          OP_JALR: begin
            alu_src_a_c = SRC_A_RS1;
            alu_src_b_c = SRC_B_IMM;
            state_d     = ST_WB;
          end
          OP_ECALL: begin
            is_ecall_c  = 1'b1;
            alu_src_b_c = SRC_B_FOUR;
            if (is_halted) begin
              state_d = ST_HALT;
            end else begin
              pc_write_c = 1'b1;
              state_d    = ST_IF;
            end
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        i_or_d_c = 1'b1;
        if (opcode == OP_LOAD) mem_read_c  = 1'b1;
        else                   mem_write_c = 1'b1;
        if (wait_done) begin
          if (opcode == OP_LOAD) begin
            state_d = ST_WB;
          end else begin
            alu_src_b_c = SRC_B_FOUR;
            pc_write_c  = 1'b1;
            state_d     = ST_IF;
          end
        end
      end
      ST_WB: begin
        alu_src_b_c = SRC_B_FOUR;
        pc_write_c  = 1'b1;
        state_d     = ST_IF;
        case (opcode)
          OP_R, OP_I: reg_write_c = 1'b1;
          OP_LOAD: begin
            reg_write_c = 1'b1;
            wb_sel_c    = WB_MDR;
          end
          OP_JALR: begin
            reg_write_c = 1'b1;
            wb_sel_c    = WB_ALU;
            pc_source_c = PC_SRC_ALUOUT;
          end
          default: ;
        endcase
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IF;
    endcase

    // The counter runs only while dwelling in IF or MEM; any other cycle rearms it.
    timer_clear = !((state_q == ST_IF || state_q == ST_MEM) && state_d == state_q);
  end

  assign pc_write  = !reset && pc_write_c;
  assign ir_write  = !reset && ir_write_c;
  assign i_or_d    = !reset && i_or_d_c;
  assign mem_read  = !reset && mem_read_c;
  assign mem_write = !reset && mem_write_c;
  assign reg_write = !reset && reg_write_c;
  assign alu_src_a = !reset && alu_src_a_c;
  assign pc_source = !reset && pc_source_c;
  assign is_ecall  = !reset && is_ecall_c;
  assign wb_sel    = reset ? '0 : wb_sel_c;
  assign alu_src_b = reset ? '0 : alu_src_b_c;
  assign alu_op    = reset ? '0 : alu_op_c;
  assign state     = reset ? '0 : state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm at MEM_WAIT=0 and MEM_WAIT=2.
module tb_multicycle_control_fsm;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011,
                         ST = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111,
                         JALR = 7'b1100111, ECALL = 7'b1110011, BAD = 7'b0000000;

  typedef struct {
    logic [17:0] v;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst2, bcond, is_halted;
  logic [6:0] opcode;

  logic       pcw0, irw0, iod0, mr0, mw0, rw0, asa0, pcs0, ec0;
  logic [1:0] wbs0, asb0, aop0;
  logic [2:0] st0;
  logic       pcw2, irw2, iod2, mr2, mw2, rw2, asa2, pcs2, ec2;
  logic [1:0] wbs2, asb2, aop2;
  logic [2:0] st2;
  logic [17:0] v0, v2;

  assign v0 = {st0, pcw0, irw0, iod0, mr0, mw0, rw0, wbs0, asa0, asb0, aop0, pcs0, ec0};
  assign v2 = {st2, pcw2, irw2, iod2, mr2, mw2, rw2, wbs2, asa2, asb2, aop2, pcs2, ec2};

  multicycle_control_fsm #(.MEM_WAIT(0)) dut0 (
    .clk(clk), .reset(rst0), .opcode(opcode), .bcond(bcond), .is_halted(is_halted),
    .pc_write(pcw0), .ir_write(irw0), .i_or_d(iod0), .mem_read(mr0), .mem_write(mw0),
    .reg_write(rw0), .wb_sel(wbs0), .alu_src_a(asa0), .alu_src_b(asb0), .alu_op(aop0),
    .pc_source(pcs0), .is_ecall(ec0), .state(st0)
  );

  multicycle_control_fsm #(.MEM_WAIT(2)) dut2 (
    .clk(clk), .reset(rst2), .opcode(opcode), .bcond(bcond), .is_halted(is_halted),
    .pc_write(pcw2), .ir_write(irw2), .i_or_d(iod2), .mem_read(mr2), .mem_write(mw2),
    .reg_write(rw2), .wb_sel(wbs2), .alu_src_a(asa2), .alu_src_b(asb2), .alu_op(aop2),
    .pc_source(pcs2), .is_ecall(ec2), .state(st2)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  task automatic check_eq(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (st pcw irw iod mr mw rw wbs asa asb aop pcs ec)",
               tag, got, exp);
    end
  endtask

  function automatic logic [17:0] vec(input logic [2:0] s, input logic pcw, irw, iod, mr, mw, rw,
                                      input logic [1:0] wbs, input logic asa,
                                      input logic [1:0] asb, aop, input logic pcs, ec);
    return {s, pcw, irw, iod, mr, mw, rw, wbs, asa, asb, aop, pcs, ec};
  endfunction

  task automatic push(input string name, inout int n, input logic [17:0] v);
    exp_t e;
    n++;
    e.v   = v;
    e.tag = $sformatf("%s c%0d", name, n);
    sb.push_back(e);
  endtask

  // Expected per-cycle outputs of one instruction, derived from the cycle table.
  task automatic push_instr(input string name, input logic [6:0] op, input int mwait,
                            input logic bc, input logic hlt, input int halt_cycles);
    int n = 0;
    for (int i = 0; i <= mwait; i++)
      push(name, n, vec(3'd0, 0, i == mwait, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0));
    push(name, n, vec(3'd1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 0, 0));
    case (op)
      R:  push(name, n, vec(3'd2, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b10, 0, 0));
      I:  push(name, n, vec(3'd2, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b01, 2'b10, 0, 0));
      LD, ST: begin
        push(name, n, vec(3'd2, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b01, 2'b00, 0, 0));
        for (int i = 0; i <= mwait; i++) begin
          if (op == LD)
            push(name, n, vec(3'd3, 0, 0, 1, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0));
          else if (i < mwait)
            push(name, n, vec(3'd3, 0, 0, 1, 0, 1, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0));
          else
            push(name, n, vec(3'd3, 1, 0, 1, 0, 1, 0, 2'b00, 0, 2'b10, 2'b00, 0, 0));
        end
      end
      BR:    push(name, n, vec(3'd2, bc, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b01, bc, 0));
      JAL:   push(name, n, vec(3'd2, 1, 0, 0, 0, 0, 1, 2'b10, 0, 2'b10, 2'b00, 1, 0));
      JALR:  push(name, n, vec(3'd2, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b01, 2'b00, 0, 0));
      ECALL: push(name, n, vec(3'd2, !hlt, 0, 0, 0, 0, 0, 2'b00, 0, 2'b10, 2'b00, 0, 1));
      default: ;
    endcase
    case (op)
      R, I, LD: push(name, n, vec(3'd4, 1, 0, 0, 0, 0, 1, (op == LD) ? 2'b01 : 2'b00,
                                  0, 2'b10, 2'b00, 0, 0));
      JALR:     push(name, n, vec(3'd4, 1, 0, 0, 0, 0, 1, 2'b10, 0, 2'b10, 2'b00, 1, 0));
      BR:       if (!bc) push(name, n, vec(3'd4, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b10, 2'b00, 0, 0));
      ST, JAL, ECALL: ;
      default:  push(name, n, vec(3'd4, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b10, 2'b00, 0, 0));
    endcase
    if (op == ECALL && hlt)
      for (int i = 0; i < halt_cycles; i++)
        push(name, n, vec(3'd5, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0));
  endtask

  // Called at posedge+1 with the DUT at the start of IF; returns at posedge+1.
  task automatic run(input string name, input int dsel, input logic [6:0] op,
                     input logic bc, input logic hlt, input int halt_cycles, input int max_cycles);
    int k = 0;
    opcode    = op;
    bcond     = bc;
    is_halted = hlt;
    push_instr(name, op, (dsel == 2) ? 2 : 0, bc, hlt, halt_cycles);
    while (sb.size() > 0 && (max_cycles == 0 || k < max_cycles)) begin
      exp_t e;
      @(negedge clk);
      e = sb.pop_front();
      check_eq(e.tag, (dsel == 2) ? v2 : v0, e.v);
      k++;
    end
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst0 = 1'b1;
    rst2 = 1'b1;
    opcode = R;
    bcond = 1'b0;
    is_halted = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_eq("reset0", v0, '0);
      check_eq("reset2", v2, '0);
    end
    @(posedge clk);
    #1 rst0 = 1'b0;

    run("R0",      0, R,     0, 0, 0, 0);
    run("I0",      0, I,     0, 0, 0, 0);
    run("LD0",     0, LD,    0, 0, 0, 0);
    run("ST0",     0, ST,    0, 0, 0, 0);
    run("BRT0",    0, BR,    1, 0, 0, 0);
    run("BRN0",    0, BR,    0, 0, 0, 0);
    run("JAL0",    0, JAL,   0, 0, 0, 0);
    run("JALR0",   0, JALR,  0, 0, 0, 0);
    run("NOP0",    0, BAD,   0, 0, 0, 0);
    run("ECALL0",  0, ECALL, 0, 0, 0, 0);
    run("HALT0",   0, ECALL, 0, 1, 20, 0);
    rst0 = 1'b1;
    is_halted = 1'b0;
    @(negedge clk);
    check_eq("reset0 from halt", v0, '0);
    @(posedge clk);
    #1 rst0 = 1'b0;
    run("R0 after halt", 0, R, 0, 0, 0, 0);
    rst0 = 1'b1;

    rst2 = 1'b0;
    run("LD2",    2, LD,    0, 0, 0, 0);
    run("ST2",    2, ST,    0, 0, 0, 0);
    run("BRT2",   2, BR,    1, 0, 0, 0);
    run("JAL2",   2, JAL,   0, 0, 0, 0);
    run("STcut2", 2, ST,    0, 0, 0, 6);
    rst2 = 1'b1;
    @(negedge clk);
    check_eq("reset2 in MEM", v2, '0);
    @(posedge clk);
    #1 rst2 = 1'b0;
    run("R2 after reset", 2, R,     0, 0, 0, 0);
    run("ECALL2",         2, ECALL, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
